block_dequantizer: RTL and testbench

//   Consumer of the coefficient table generator. Accepts one 64-entry zigzag-ordered block of

---
 rtl/block_dequantizer_pkg.sv | 32 +++
 rtl/block_dequantizer_zigzag_rom.sv | 13 +
 rtl/block_dequantizer.sv | 134 +++++++++++++
 tb/tb_block_dequantizer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_dequantizer_pkg.sv
// Shared definitions for the block dequantizer.
//   BLOCK_SIZE : coefficients per 8x8 block
//   state_t    : controller states
//   ZZ_TO_NAT  : zigzag scan index -> raster (row-major) position
//   zz_to_nat  : lookup helper over ZZ_TO_NAT
package block_dequantizer_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] ZZ_TO_NAT [BLOCK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [IDX_W-1:0] zz_to_nat(input logic [IDX_W-1:0] zz);
        return ZZ_TO_NAT[zz];
    endfunction

endpackage

// File: rtl/block_dequantizer_zigzag_rom.sv
// Combinational zigzag-to-raster index ROM.
//   zz_idx  : zigzag scan index (0..63)
//   nat_pos : matching raster position in the 8x8 block
module zigzag_rom
    import block_dequantizer_pkg::*;
(
    input  logic [IDX_W-1:0] zz_idx,
    output logic [IDX_W-1:0] nat_pos
);

    assign nat_pos = zz_to_nat(zz_idx);

endmodule

// File: rtl/block_dequantizer.sv
// Block dequantizer: captures one zigzag-ordered block of signed coefficients,
// multiplies each by its quant-table entry with one shared multiplier (one
// coefficient per clock) and scatters the products into raster order.
//   clk, rst              : clock, async active-high reset
//   in_block/in_valid     : zigzag block input, in_ready high while idle
//   q_we/q_addr/q_data    : quant-table write port (zigzag index), idle only
//   out_block/out_valid   : raster-order result, held until out_ready
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a block; quant writes accepted
// ST_PROC | one coefficient dequantised per clock, idx 0..63
// ST_DONE | out_block complete, waiting for out_ready
module block_dequantizer
    import block_dequantizer_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BLOCK_SIZE*COEF_W-1:0] in_block,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         q_we,
    input  logic [IDX_W-1:0]             q_addr,
    input  logic [Q_W-1:0]               q_data,
    output logic [BLOCK_SIZE*OUT_W-1:0]  out_block,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int PROD_W = COEF_W + Q_W + 1;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [BLOCK_SIZE*COEF_W-1:0]  coef_q, coef_d;
    logic [Q_W-1:0]                quant_q [BLOCK_SIZE];
    logic [Q_W-1:0]                quant_d [BLOCK_SIZE];
    logic [BLOCK_SIZE*OUT_W-1:0]   out_block_q, out_block_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [COEF_W-1:0]      coef_sel;
    logic [Q_W-1:0]                q_sel;
    logic signed [PROD_W-1:0]      prod;
    logic signed [OUT_W-1:0]       prod_ext;
    logic [IDX_W-1:0]              nat_pos;

    zigzag_rom u_zigzag_rom (
        .zz_idx  (idx_q),
        .nat_pos (nat_pos)
    );

    // Quant entry is unsigned: a zero MSB keeps it positive in the signed product.
    always_comb begin
        coef_sel = coef_q[idx_q*COEF_W +: COEF_W];
        q_sel    = quant_q[idx_q];
        prod     = coef_sel * $signed({1'b0, q_sel});
        prod_ext = OUT_W'(prod);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        coef_d      = coef_q;
        quant_d     = quant_q;
        out_block_d = out_block_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                // Write lands in the same edge that accepts a block; reads start next cycle.
                if (q_we) begin
                    quant_d[q_addr] = q_data;
                end
                if (in_valid) begin
                    coef_d     = in_block;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_PROC;
                end
            end
            ST_PROC: begin
                out_block_d[nat_pos*OUT_W +: OUT_W] = prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(BLOCK_SIZE - 1)) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                idx_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            coef_q      <= '0;
            quant_q     <= '{default: Q_W'(1)};
            out_block_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coef_q      <= coef_d;
            quant_q     <= quant_d;
            out_block_q <= out_block_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

endmodule

// File: tb/tb_block_dequantizer.sv
// Directed bench for block_dequantizer: table of single-position checks plus
// hand sequences for latency, backpressure, quant-write timing and reset.
module tb_block_dequantizer;

    localparam int COEF_W = 8;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [64*COEF_W-1:0]    in_block = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    q_we = 1'b0;
    logic [5:0]              q_addr = '0;
    logic [Q_W-1:0]          q_data = '0;
    logic [64*OUT_W-1:0]     out_block;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    block_dequantizer #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_we      (q_we),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Standard JPEG zigzag order: zigzag index -> raster position.
    int zz_tb [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        string      name;
        bit         ramp;
        logic [7:0] cfill, c0, c5;
        logic [7:0] qfill, q0, q5;
        int         pos;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [64*COEF_W-1:0] mk_blk(input bit ramp, input logic [7:0] cfill,
                                                    input logic [7:0] c0, input logic [7:0] c5);
        logic [64*COEF_W-1:0] b;
        for (int k = 0; k < 64; k++) b[k*8 +: 8] = ramp ? 8'(k) : cfill;
        b[7:0]    = c0;
        b[5*8 +: 8] = c5;
        return b;
    endfunction

    function automatic logic [15:0] out_at(input int p);
        return out_block[p*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_quant(input logic [7:0] fill, input logic [7:0] q0, input logic [7:0] q5);
        for (int k = 0; k < 64; k++) begin
            q_we   = 1'b1;
            q_addr = 6'(k);
            q_data = (k == 0) ? q0 : ((k == 5) ? q5 : fill);
            tick();
        end
        q_we = 1'b0;
    endtask

    task automatic start_block(input logic [64*COEF_W-1:0] blk);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        in_block = blk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_reached", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_blk();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        vec_t v;

        vecs.push_back('{"ramp_r0",  1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1,  0, 16'd0});
        vecs.push_back('{"ramp_r1",  1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1,  1, 16'd1});
        vecs.push_back('{"ramp_r8",  1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1,  8, 16'd2});
        vecs.push_back('{"ramp_r16", 1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1, 16, 16'd3});
        vecs.push_back('{"ramp_r9",  1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1,  9, 16'd4});
        vecs.push_back('{"ramp_r2",  1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1,  2, 16'd5});
        vecs.push_back('{"ramp_r63", 1'b1, 8'h00, 8'h00, 8'h05, 8'd1, 8'd1, 8'd1, 63, 16'd63});
        vecs.push_back('{"q16_r0",   1'b1, 8'h00, 8'h80, 8'h7F, 8'd1, 8'd16, 8'd2, 0, 16'hF800});
        vecs.push_back('{"q2_r2",    1'b1, 8'h00, 8'h80, 8'h7F, 8'd1, 8'd16, 8'd2, 2, 16'h00FE});
        vecs.push_back('{"q_mix_r8", 1'b1, 8'h00, 8'h80, 8'h7F, 8'd1, 8'd16, 8'd2, 8, 16'h0002});
        vecs.push_back('{"q_mix_r63",1'b1, 8'h00, 8'h80, 8'h7F, 8'd1, 8'd16, 8'd2, 63, 16'h003F});
        vecs.push_back('{"min_r0",   1'b0, 8'h80, 8'h80, 8'h80, 8'd255, 8'd255, 8'd255, 0, 16'h8080});
        vecs.push_back('{"min_r37",  1'b0, 8'h80, 8'h80, 8'h80, 8'd255, 8'd255, 8'd255, 37, 16'h8080});
        vecs.push_back('{"max_r0",   1'b0, 8'h7F, 8'h7F, 8'h7F, 8'd255, 8'd255, 8'd255, 0, 16'h7E81});
        vecs.push_back('{"max_r63",  1'b0, 8'h7F, 8'h7F, 8'h7F, 8'd255, 8'd255, 8'd255, 63, 16'h7E81});
        vecs.push_back('{"neg1_r20", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'd255, 8'd255, 8'd255, 20, 16'hFF01});

        #23 rst = 1'b0;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_block_zero", {31'd0, |out_block}, 32'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            load_quant(v.qfill, v.q0, v.q5);
            start_block(mk_blk(v.ramp, v.cfill, v.c0, v.c5));
            check({v.name, "_in_ready_proc"}, {31'd0, in_ready}, 32'd0);
            wait_done(n);
            check({v.name, "_latency"}, 32'(n), 32'd64);
            check(v.name, {16'd0, out_at(v.pos)}, {16'd0, v.exp});
            release_blk();
        end

        // Backpressure: hold out_ready low, poke in_valid, result must stay put.
        load_quant(8'd1, 8'd1, 8'd1);
        start_block(mk_blk(1'b1, 8'h00, 8'h00, 8'h05));
        wait_done(n);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_block = mk_blk(1'b0, 8'h11, 8'h11, 8'h11);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        for (int k = 0; k < 64; k++) begin
            check($sformatf("bp_full_zz%0d", k), {16'd0, out_at(zz_tb[k])}, 32'(k));
        end
        release_blk();
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);

        // Quant write coinciding with acceptance is used by that block.
        q_we     = 1'b1;
        q_addr   = 6'd0;
        q_data   = 8'd3;
        in_block = mk_blk(1'b1, 8'h00, 8'h05, 8'h05);
        in_valid = 1'b1;
        tick();
        q_we     = 1'b0;
        in_valid = 1'b0;
        wait_done(n);
        check("we_with_valid_r0", {16'd0, out_at(0)}, 32'd15);
        release_blk();

        // Quant write during PROC is dropped, in this block and the next.
        load_quant(8'd1, 8'd1, 8'd1);
        start_block(mk_blk(1'b1, 8'h00, 8'h00, 8'h05));
        repeat (10) tick();
        q_we   = 1'b1;
        q_addr = 6'd50;
        q_data = 8'd9;
        tick();
        q_we = 1'b0;
        wait_done(n);
        check("proc_we_ignored_a", {16'd0, out_at(zz_tb[50])}, 32'd50);
        release_blk();
        start_block(mk_blk(1'b1, 8'h00, 8'h00, 8'h05));
        wait_done(n);
        check("proc_we_ignored_b", {16'd0, out_at(zz_tb[50])}, 32'd50);
        release_blk();

        // Reset at idx=30 clears everything immediately.
        start_block(mk_blk(1'b1, 8'h00, 8'h00, 8'h05));
        repeat (20) tick();
        q_we   = 1'b1;
        q_addr = 6'd3;
        q_data = 8'd7;
        tick();
        q_we = 1'b0;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_block_zero", {31'd0, |out_block}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #3 rst = 1'b0;
        tick();
        start_block(mk_blk(1'b1, 8'h00, 8'h00, 8'h05));
        wait_done(n);
        check("post_rst_r_zz3", {16'd0, out_at(zz_tb[3])}, 32'd3);
        check("post_rst_r_zz63", {16'd0, out_at(zz_tb[63])}, 32'd63);
        release_blk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
